spigot_e_core: RTL and testbench

Parametrised streaming engine that computes the digits of e with the mixed-radix spigot algorithm (e = 2 + 1/2(1 + 1/3(1 + 1/4(…)))). Successor to the fixed-function spigot-e design: term count and digit count are parameters, output radix is selectable per run (decimal or hexadecimal), and digits leave through a valid/ready handshake instead of a free-running output. Sits behind the Tiny Tapeout top-level wrapper, which maps its handshake and control onto `ui_in`/`uo_out`/`uio_*`.

---
 rtl/spigot_e_pkg.sv | 27 ++
 rtl/spigot_e_divmod.sv | 71 +++++++
 rtl/spigot_e_core.sv | 173 +++++++++++++++++
 tb/tb_spigot_e_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spigot_e_pkg.sv
// Shared types and helpers for the spigot e digit engine.
// Holds the FSM encoding, radix constants and width helpers.
package spigot_e_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EMIT_INT,
    S_LOAD,
    S_DIV,
    S_WRITE,
    S_EMIT,
    S_DONE
  } state_t;

  localparam int RADIX_DEC = 10;
  localparam int RADIX_HEX = 16;

  function automatic int aw_of(input int nterms);
    return $clog2(nterms + 2);
  endfunction

  function automatic int xw_of(input int nterms);
    return aw_of(nterms) + 4;
  endfunction

endpackage

// File: rtl/spigot_e_divmod.sv
// Iterative restoring divider, one quotient bit per cycle.
// The first bit is resolved on the start edge; done follows XW cycles later.
module spigot_e_divmod #(
  parameter int XW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] dividend,
  input  logic [XW-1:0] divisor,
  output logic [XW-1:0] quotient,
  output logic [XW-1:0] remainder,
  output logic          done
);

  localparam int CW = $clog2(XW + 1);

  logic [XW-1:0] rem_q;
  logic [XW-1:0] quo_q;
  logic [XW-1:0] dvs_q;
  logic [CW-1:0] cnt;
  logic          run;

  logic [XW-1:0] src_r;
  logic [XW-1:0] src_q;
  logic [XW-1:0] src_d;
  logic [XW:0]   trial;
  logic [XW-1:0] nr;
  logic [XW-1:0] nq;

  always_comb begin
    src_r = start ? '0 : rem_q;
    src_q = start ? dividend : quo_q;
    src_d = start ? divisor : dvs_q;
    trial = {src_r, src_q[XW-1]};
    nr    = trial[XW-1:0];
    nq    = {src_q[XW-2:0], 1'b0};
    if (trial >= {1'b0, src_d}) begin
      // True difference is below the divisor, so XW-bit wrap is exact.
      nr = trial[XW-1:0] - src_d;
      nq = {src_q[XW-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      rem_q <= nr;
      quo_q <= nq;
      dvs_q <= divisor;
      cnt   <= CW'(XW - 1);
      run   <= 1'b1;
      done  <= 1'b0;
    end else if (run) begin
      rem_q <= nr;
      quo_q <= nq;
      cnt   <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/spigot_e_core.sv
// Streaming mixed-radix spigot engine for the digits of e.
// Emits the integer digit then NDIGITS fractional digits over valid/ready.
module spigot_e_core #(
  parameter int NTERMS  = 64,
  parameter int NDIGITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       base_hex,
  output logic [3:0] digit,
  output logic       digit_first,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       busy,
  output logic       done
);

  import spigot_e_pkg::*;

  localparam int AW = aw_of(NTERMS);
  localparam int XW = xw_of(NTERMS);
  localparam int IW = $clog2(NTERMS);
  localparam int CW = $clog2(NDIGITS + 1);

  state_t state;
  state_t state_n;

  logic [AW-1:0] k;
  logic [CW-1:0] cnt;
  logic [3:0]    carry;
  logic          hex;

  logic [AW-1:0] arr [NTERMS];
  logic [IW-1:0] ki;
  logic [AW-1:0] rd;

  logic [XW-1:0] a_x;
  logic [XW-1:0] prod;
  logic [XW-1:0] x;
  logic [XW-1:0] dvs;
  logic [XW-1:0] q;
  logic [XW-1:0] r;
  logic          dv_done;
  logic          dv_start;
  logic          k_top;
  logic          last;
  logic          unused_bits;

  assign ki    = k[IW-1:0];
  assign rd    = arr[ki];
  assign k_top = (k == AW'(NTERMS - 1));
  assign last  = (cnt == CW'(NDIGITS - 1));

  // Base 10 as 8a+2a keeps the datapath to shifts and one adder.
  always_comb begin
    a_x  = XW'(rd);
    prod = hex ? (a_x << 4) : ((a_x << 3) + (a_x << 1));
    x    = prod + XW'(carry);
    dvs  = XW'(k) + XW'(2);
  end

  assign dv_start = (state == S_LOAD);

  spigot_e_divmod #(
    .XW(XW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (dv_start),
    .dividend (x),
    .divisor  (dvs),
    .quotient (q),
    .remainder(r),
    .done     (dv_done)
  );

  assign unused_bits = ^{q[XW-1:4], r[XW-1:AW]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:     if (start) state_n = S_INIT;
      S_DONE:     if (start) state_n = S_INIT;
      S_INIT:     if (k_top) state_n = S_EMIT_INT;
      S_EMIT_INT: if (digit_ready) state_n = S_LOAD;
      S_LOAD:     state_n = S_DIV;
      S_DIV:      if (dv_done) state_n = S_WRITE;
      S_WRITE:    state_n = (k == '0) ? S_EMIT : S_LOAD;
      S_EMIT: begin
        if (digit_ready) state_n = last ? S_DONE : S_LOAD;
      end
      default:    state_n = S_IDLE;
    endcase
  end

  always_comb begin
    digit       = 4'd0;
    digit_first = 1'b0;
    digit_valid = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_EMIT_INT: begin
        digit       = 4'd2;
        digit_first = 1'b1;
        digit_valid = 1'b1;
      end
      S_EMIT: begin
        digit       = carry;
        digit_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      cnt   <= '0;
      carry <= '0;
      hex   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            hex <= base_hex;
            cnt <= '0;
            k   <= '0;
          end
        end
        S_INIT: begin
          if (!k_top) k <= k + 1'b1;
        end
        S_EMIT_INT: begin
          if (digit_ready) begin
            carry <= '0;
            k     <= AW'(NTERMS - 1);
          end
        end
        S_WRITE: begin
          carry <= q[3:0];
          if (k != '0) k <= k - 1'b1;
        end
        S_EMIT: begin
          if (digit_ready) begin
            cnt   <= cnt + 1'b1;
            carry <= '0;
            k     <= AW'(NTERMS - 1);
          end
        end
        default: ;
      endcase
    end
  end

  // Array holds no reset: INIT rewrites every entry before use.
  always_ff @(posedge clk) begin
    if (state == S_INIT) arr[ki] <= AW'(1);
    else if (state == S_WRITE) arr[ki] <= r[AW-1:0];
  end

endmodule

// File: tb/tb_spigot_e_core.sv
// Directed bench for spigot_e_core with a digit scoreboard queue.
// Also drives a standalone divider instance for unit checks.
module tb_spigot_e_core;

  logic       clk;
  logic       rst;
  logic       start;
  logic       base_hex;
  logic [3:0] digit;
  logic       digit_first;
  logic       digit_valid;
  logic       digit_ready;
  logic       busy;
  logic       done;

  logic        dv_start;
  logic [10:0] dv_dividend;
  logic [10:0] dv_divisor;
  logic [10:0] dv_q;
  logic [10:0] dv_r;
  logic        dv_done;

  int checks;
  int failures;
  logic [4:0] sb [$];

  int dec_d [33] = '{2, 7, 1, 8, 2, 8, 1, 8, 2, 8, 4,
                     5, 9, 0, 4, 5, 2, 3, 5, 3, 6, 0,
                     2, 8, 7, 4, 7, 1, 3, 5, 2, 6, 6};
  int hex_d [33] = '{2, 11, 7, 14, 1, 5, 1, 6, 2, 8, 10,
                     14, 13, 2, 10, 6, 10, 11, 15, 7, 1, 5,
                     8, 8, 0, 9, 12, 15, 4, 15, 3, 12, 7};

  spigot_e_core #(
    .NTERMS (64),
    .NDIGITS(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_hex   (base_hex),
    .digit      (digit),
    .digit_first(digit_first),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .busy       (busy),
    .done       (done)
  );

  spigot_e_divmod #(
    .XW(11)
  ) dv (
    .clk      (clk),
    .rst      (rst),
    .start    (dv_start),
    .dividend (dv_dividend),
    .divisor  (dv_divisor),
    .quotient (dv_q),
    .remainder(dv_r),
    .done     (dv_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_run(input bit hx, input int n);
    for (int i = 0; i < n; i++) begin
      int d;
      d = hx ? hex_d[i] : dec_d[i];
      sb.push_back({(i == 0), d[3:0]});
    end
  endtask

  task automatic pulse_start(input bit hx);
    base_hex = hx;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic collect(input int n,
                         input int stall_idx,
                         input int stall_len);
    int got;
    int wait_c;
    logic [3:0] held;
    logic [4:0] exp;
    got = 0;
    wait_c = 0;
    digit_ready = 1'b1;
    while (got < n) begin
      @(negedge clk);
      if (digit_valid) begin
        if (got == stall_idx && stall_len > 0) begin
          digit_ready = 1'b0;
          held = digit;
          repeat (stall_len) @(negedge clk);
          chk("stall_valid", 32'(digit_valid), 32'd1);
          chk("stall_digit", 32'(digit), 32'(held));
          digit_ready = 1'b1;
        end
        exp = sb.pop_front();
        chk($sformatf("digit%0d", got),
            32'({digit_first, digit}), 32'(exp));
        got++;
        wait_c = 0;
      end else begin
        wait_c++;
        if (wait_c > 2000) begin
          checks++;
          failures++;
          $error("FAIL timeout observed=%0d digits expected=%0d",
                 got, n);
          sb.delete();
          return;
        end
      end
    end
  endtask

  initial begin
    int lat;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    base_hex = 1'b0;
    digit_ready = 1'b0;
    dv_start = 1'b0;
    dv_dividend = '0;
    dv_divisor = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_first", 32'(digit_first), 32'd0);
    chk("rst_valid", 32'(digit_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    dv_dividend = 11'd27;
    dv_divisor = 11'd5;
    dv_start = 1'b1;
    @(negedge clk);
    dv_start = 1'b0;
    lat = 1;
    while (!dv_done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("div_lat", 32'(lat), 32'd11);
    chk("div_q", 32'(dv_q), 32'd5);
    chk("div_r", 32'(dv_r), 32'd2);

    dv_dividend = 11'd1055;
    dv_divisor = 11'd2;
    dv_start = 1'b1;
    @(negedge clk);
    dv_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("divmax_done", 32'(dv_done), 32'd1);
    chk("divmax_q", 32'(dv_q), 32'd527);
    chk("divmax_r", 32'(dv_r), 32'd1);

    push_run(1'b0, 33);
    pulse_start(1'b0);
    chk("busy_rise", 32'(busy), 32'd1);
    collect(3, -1, 0);
    pulse_start(1'b1);
    chk("busy_ignore", 32'(busy), 32'd1);
    collect(30, -1, 0);
    @(negedge clk);
    chk("dec_done", 32'(done), 32'd1);
    chk("dec_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("done_hold", 32'(done), 32'd1);

    push_run(1'b0, 5);
    pulse_start(1'b0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    collect(5, -1, 0);
    do_reset();

    push_run(1'b1, 33);
    pulse_start(1'b1);
    collect(33, -1, 0);
    @(negedge clk);
    chk("hex_done", 32'(done), 32'd1);
    chk("hex_busy", 32'(busy), 32'd0);

    push_run(1'b0, 6);
    pulse_start(1'b0);
    collect(6, 3, 100);
    do_reset();

    push_run(1'b0, 4);
    pulse_start(1'b0);
    collect(4, -1, 0);
    repeat (305) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    do_reset();
    chk("mid_digit", 32'(digit), 32'd0);
    chk("mid_first", 32'(digit_first), 32'd0);
    chk("mid_valid", 32'(digit_valid), 32'd0);
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("mid_idle", 32'(busy), 32'd0);
    push_run(1'b0, 4);
    pulse_start(1'b0);
    collect(4, -1, 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
